// File: rtl/core_io_pkg.sv
// Shared types and constants for the core byte-output path (serial transmitter).
package core_io_pkg;

  localparam int unsigned UART_DATA_BITS = 8;
  localparam logic        TX_IDLE_LEVEL  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

endpackage

// File: rtl/core_uart_tx_if.sv
// Core-side output port of the serial transmitter: byte handshake plus line and status.
interface core_uart_tx_if
  import core_io_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) ();

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic                      OUTE;
  logic [UART_DATA_BITS-1:0] OUTDATA;
  logic                      OUT_READY;
  logic                      TXD;
  logic                      TX_BUSY;
  logic [CNT_W-1:0]          FIFO_COUNT;

  modport master (
    output OUTE, OUTDATA,
    input  OUT_READY, TXD, TX_BUSY, FIFO_COUNT
  );

  modport slave (
    input  OUTE, OUTDATA,
    output OUT_READY, TXD, TX_BUSY, FIFO_COUNT
  );

endinterface

// File: rtl/core_tx_fifo.sv
// Byte FIFO feeding the serial transmitter; DEPTH must be a power of two >= 2.
module core_tx_fifo
  import core_io_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        push_i,
  input  logic [UART_DATA_BITS-1:0]   data_i,
  input  logic                        pop_i,
  output logic [UART_DATA_BITS-1:0]   data_o,
  output logic                        full_o,
  output logic                        empty_o,
  output logic [$clog2(DEPTH):0]      count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [UART_DATA_BITS-1:0] mem_q [DEPTH];
  logic [AW-1:0]             wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]             rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]             count_q, count_d;
  logic                      do_push, do_pop;

  // Full blocks a push even when a pop lands on the same edge.
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/core_uart_tx.sv
// Buffered async serial transmitter: 8 data bits LSB first, one stop bit.
// Define CORE_UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module core_uart_tx
  import core_io_pkg::*;
#(
  parameter int unsigned CLK_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic          CLK,
  input  logic          RST_N,
  core_uart_tx_if.slave bus
);

  localparam int unsigned CW = $clog2(CLK_PER_BIT);
  localparam int unsigned IW = $clog2(UART_DATA_BITS);
  localparam int unsigned NW = $clog2(FIFO_DEPTH) + 1;

  tx_state_t                 state_q, state_d;
  logic [CW-1:0]             bit_cnt_q, bit_cnt_d;
  logic [IW-1:0]             bit_idx_q, bit_idx_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      txd_q, txd_d;
  logic                      bit_end;
  logic                      fifo_pop, fifo_full, fifo_empty;
  logic [UART_DATA_BITS-1:0] fifo_data;
  logic [NW-1:0]             fifo_count;
`ifdef CORE_UART_TX_PARITY_EN
  logic                      parity_q, parity_d;
`endif

  core_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_ni  (RST_N),
    .push_i  (bus.OUTE),
    .data_i  (bus.OUTDATA),
    .pop_i   (fifo_pop),
    .data_o  (fifo_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign bus.OUT_READY  = !fifo_full;
  assign bus.TXD        = txd_q;
  assign bus.TX_BUSY    = (state_q != IDLE) || !fifo_empty;
  assign bus.FIFO_COUNT = fifo_count;

  assign bit_end = (bit_cnt_q == CW'(CLK_PER_BIT - 1));

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    fifo_pop  = 1'b0;
`ifdef CORE_UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif

    if (state_q != IDLE) bit_cnt_d = bit_end ? '0 : bit_cnt_q + CW'(1);

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          shift_d   = fifo_data;
          bit_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = START;
`ifdef CORE_UART_TX_PARITY_EN
          parity_d  = ^fifo_data;
`endif
        end
      end
      START: if (bit_end) state_d = DATA;
      DATA: begin
        if (bit_end) begin
          if (bit_idx_q == IW'(UART_DATA_BITS - 1)) begin
`ifdef CORE_UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + IW'(1);
            shift_d   = shift_q >> 1;
          end
        end
      end
      PARITY:  if (bit_end) state_d = STOP;
      STOP:    if (bit_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // TXD is registered from the next state so the line changes on the same edge as the state.
  always_comb begin
    txd_d = TX_IDLE_LEVEL;
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
`ifdef CORE_UART_TX_PARITY_EN
      PARITY:  txd_d = parity_d;
`endif
      default: txd_d = TX_IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      txd_q     <= TX_IDLE_LEVEL;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      txd_q     <= txd_d;
    end
  end

`ifdef CORE_UART_TX_PARITY_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) parity_q <= 1'b0;
    else        parity_q <= parity_d;
  end
`endif

endmodule

// File: tb/tb_core_uart_tx.sv
// Self-checking bench for core_uart_tx: directed stimulus, byte scoreboard, line decoder.
module tb_core_uart_tx;

  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 4;
`ifdef CORE_UART_TX_PARITY_EN
  localparam int unsigned NBITS = 11;
`else
  localparam int unsigned NBITS = 10;
`endif
  localparam int unsigned FL     = NBITS * CPB;
  localparam int unsigned PERIOD = FL + 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  logic [7:0] sb[$];
  int   starts[$];
  logic mon_abort = 1'b0;

  core_uart_tx_if #(.FIFO_DEPTH(DEPTH)) bus ();

  core_uart_tx #(
    .CLK_PER_BIT (CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int unsigned i);
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
`ifdef CORE_UART_TX_PARITY_EN
    if (i == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic mon_wait(input int unsigned n);
    repeat (n) begin
      @(negedge clk);
      if (!rst_n) mon_abort = 1'b1;
    end
  endtask

  // Line decoder: samples each bit mid-cell and checks against the scoreboard head.
  initial begin : monitor
    logic [7:0] d;
    logic [7:0] exp;
    logic       sbit, stp;
    logic       pbit;
    int         st;
    forever begin
      @(negedge clk);
      if (rst_n && bus.TXD === 1'b0) begin
        st = cyc;
        mon_abort = 1'b0;
        pbit = 1'b0;
        mon_wait(CPB / 2);
        sbit = bus.TXD;
        for (int i = 0; i < 8; i++) begin
          mon_wait(CPB);
          d[i] = bus.TXD;
        end
`ifdef CORE_UART_TX_PARITY_EN
        mon_wait(CPB);
        pbit = bus.TXD;
`endif
        mon_wait(CPB);
        stp = bus.TXD;
        if (!mon_abort) begin
          if (sb.size() != 0) exp = sb.pop_front();
          else                exp = 8'hxx;
          starts.push_back(st);
          check("frame_start", 32'(sbit), 0);
          check("frame_data", 32'(d), 32'(exp));
`ifdef CORE_UART_TX_PARITY_EN
          check("frame_parity", 32'(pbit), 32'(^exp));
`endif
          check("frame_stop", 32'(stp), 1);
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Caller is at a negedge; returns at the negedge after the accepting edge.
  task automatic push(input logic [7:0] b, output int acc);
    int n;
    n = 0;
    bus.OUTE    = 1'b1;
    bus.OUTDATA = b;
    while (bus.OUT_READY !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) check("push_ready_timeout", 32'(bus.OUT_READY), 1);
    @(posedge clk);
    sb.push_back(b);
    #1;
    acc = cyc;
    bus.OUTE = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (bus.TX_BUSY !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(bus.TX_BUSY), 0);
    repeat (4) @(negedge clk);
  endtask

  task automatic check_periods(input string tag, input int nframes);
    check({tag, "_frames"}, 32'(starts.size()), 32'(nframes));
    for (int i = 0; i + 1 < starts.size(); i++)
      check({tag, "_period"}, 32'(starts[i+1] - starts[i]), PERIOD);
    check({tag, "_sb_empty"}, 32'(sb.size()), 0);
  endtask

  initial begin : stim
    int e, p2, tmp;
    bus.OUTE    = 1'b0;
    bus.OUTDATA = '0;

    repeat (3) @(negedge clk);
    check("rst_txd", 32'(bus.TXD), 1);
    check("rst_ready", 32'(bus.OUT_READY), 1);
    check("rst_busy", 32'(bus.TX_BUSY), 0);
    check("rst_count", 32'(bus.FIFO_COUNT), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte 0xA5 from idle
    push(8'hA5, e);
    check("single_count1", 32'(bus.FIFO_COUNT), 1);
    check("single_txd_idle", 32'(bus.TXD), 1);
    check("single_busy", 32'(bus.TX_BUSY), 1);
    @(negedge clk);
    check("single_count0", 32'(bus.FIFO_COUNT), 0);
    for (int k = 0; k < int'(FL); k++) begin
      check("single_bit", 32'(bus.TXD), 32'(frame_bit(8'hA5, k / CPB)));
      if (k == int'(FL) - 1) check("single_busy_stop", 32'(bus.TX_BUSY), 1);
      @(negedge clk);
    end
    check("single_busy_done", 32'(bus.TX_BUSY), 0);
    check("single_txd_done", 32'(bus.TXD), 1);
    repeat (5) @(negedge clk);
    check_periods("single", 1);
    starts.delete();

    // Fill: five consecutive pushes, then a push while full is dropped
    push(8'h01, tmp);
    push(8'h02, p2);
    push(8'h03, tmp);
    push(8'h04, tmp);
    push(8'h05, tmp);
    check("fill_count", 32'(bus.FIFO_COUNT), 4);
    check("fill_ready_low", 32'(bus.OUT_READY), 0);
    bus.OUTE    = 1'b1;
    bus.OUTDATA = 8'hEE;
    @(posedge clk);
    #1 bus.OUTE = 1'b0;
    @(negedge clk);
    check("fill_drop_count", 32'(bus.FIFO_COUNT), 4);
    wait_until(p2 + FL);
    check("fill_ready_before_pop", 32'(bus.OUT_READY), 0);
    @(negedge clk);
    check("fill_ready_after_pop", 32'(bus.OUT_READY), 1);
    check("fill_count_after_pop", 32'(bus.FIFO_COUNT), 3);
    wait_idle("fill_idle", 8 * PERIOD);
    check_periods("fill", 5);
    starts.delete();

    // Simultaneous push and pop
    push(8'h11, e);
    push(8'h22, tmp);
    check("simul_count1", 32'(bus.FIFO_COUNT), 1);
    push(8'h33, tmp);
    check("simul_count2", 32'(bus.FIFO_COUNT), 2);
    wait_until(e + 1 + FL);
    check("simul_count_pre", 32'(bus.FIFO_COUNT), 2);
    push(8'h44, tmp);
    check("simul_count_post", 32'(bus.FIFO_COUNT), 2);
    check("simul_txd_start", 32'(bus.TXD), 0);
    wait_idle("simul_idle", 6 * PERIOD);
    check_periods("simul", 4);
    starts.delete();

    // Asynchronous reset during data bit 3
    push(8'hA5, e);
    push(8'h77, tmp);
    wait_until(e + 1 + 4 * CPB + 1);
    check("rstmid_pre_txd", 32'(bus.TXD), 0);
    #1 rst_n = 1'b0;
    sb.delete();
    #1;
    check("rstmid_txd", 32'(bus.TXD), 1);
    check("rstmid_count", 32'(bus.FIFO_COUNT), 0);
    check("rstmid_busy", 32'(bus.TX_BUSY), 0);
    check("rstmid_ready", 32'(bus.OUT_READY), 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    starts.delete();
    push(8'h3C, e);
    wait_idle("rstmid_idle", 3 * PERIOD);
    check_periods("rstmid", 1);
    starts.delete();

    // Back-to-back frames with odd and even parity data
    push(8'h07, e);
    push(8'h03, tmp);
    wait_idle("par_idle", 4 * PERIOD);
    check_periods("par", 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
